// File: rtl/sfx_tone_arbiter_if.sv
// Bus between game logic / music chain and the SFX tone arbiter.
//   enable      game running; low aborts and mutes
//   sfx_req     one-cycle request pulses: [0] rotate, [1] drop, [2] line clear, [3] game over
//   music_freq  background music tone in Hz (0 = rest)
//   tone_freq   registered frequency for the tone PWM generator in Hz (0 = silence)
//   sfx_active  high while an effect is playing
//   sfx_id      index of the effect playing (valid while sfx_active)
//   sfx_done    one-cycle pulse when an effect completes its last note
interface sfx_tone_arbiter_if;
  logic        enable;
  logic [3:0]  sfx_req;
  logic [31:0] music_freq;
  logic [31:0] tone_freq;
  logic        sfx_active;
  logic [1:0]  sfx_id;
  logic        sfx_done;

  modport master (
    output enable, sfx_req, music_freq,
    input  tone_freq, sfx_active, sfx_id, sfx_done
  );

  modport slave (
    input  enable, sfx_req, music_freq,
    output tone_freq, sfx_active, sfx_id, sfx_done
  );
endinterface

// File: rtl/sfx_tone_arbiter.sv
// Shares the speaker tone generator between background music and sound effects.
// Sequences multi-note effects from a small ROM, arbitrates by fixed priority
// (id3 > id2 > id1 > id0) and lets equal/higher priority requests pre-empt.
// Ports: clk, reset (async, active-high), bus (sfx_tone_arbiter_if.slave).
// Optional feature: define SFX_QUEUE_EN to add a one-deep pending slot that
// holds a rejected lower-priority request until the current effect finishes.
module sfx_tone_arbiter #(
  parameter int unsigned TICKS_PER_NOTE = 12_500_000,
  parameter int unsigned GAP_TICKS      = 1_250_000
) (
  input logic             clk,
  input logic             reset,
  sfx_tone_arbiter_if.slave bus
);

  localparam int unsigned CNT_MAX_RAW = (TICKS_PER_NOTE > GAP_TICKS) ? TICKS_PER_NOTE : GAP_TICKS;
  localparam int unsigned CNT_MAX     = (CNT_MAX_RAW > 2) ? CNT_MAX_RAW : 2;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(TICKS_PER_NOTE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       id_q, id_d;
  logic [31:0]      tone_q, tone_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
`ifdef SFX_QUEUE_EN
  logic             pend_vld_q, pend_vld_d;
  logic [1:0]       pend_id_q, pend_id_d;
`endif

  logic       req_vld_c;
  logic [1:0] req_id_c;
  logic       start_c;
  logic [1:0] start_id_c;
  logic       complete_c;

  // Effect ROM: frequency of note idx of effect id.
  function automatic logic [31:0] note_freq(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b00_00: note_freq = 32'd988;
      4'b01_00: note_freq = 32'd523;
      4'b01_01: note_freq = 32'd262;
      4'b10_00: note_freq = 32'd523;
      4'b10_01: note_freq = 32'd659;
      4'b10_10: note_freq = 32'd784;
      4'b10_11: note_freq = 32'd1047;
      4'b11_00: note_freq = 32'd392;
      4'b11_01: note_freq = 32'd330;
      4'b11_10: note_freq = 32'd262;
      4'b11_11: note_freq = 32'd131;
      default:  note_freq = 32'd0;
    endcase
  endfunction

  // Index of the final note of each effect.
  function automatic logic [1:0] last_idx(input logic [1:0] id);
    case (id)
      2'd0:    last_idx = 2'd0;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  // Highest-priority request this cycle; ignored while disabled.
  always_comb begin
    req_vld_c = bus.enable && (|bus.sfx_req);
    if (bus.sfx_req[3])      req_id_c = 2'd3;
    else if (bus.sfx_req[2]) req_id_c = 2'd2;
    else if (bus.sfx_req[1]) req_id_c = 2'd1;
    else                     req_id_c = 2'd0;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      idx_q      <= '0;
      id_q       <= '0;
      tone_q     <= '0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef SFX_QUEUE_EN
      pend_vld_q <= 1'b0;
      pend_id_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      id_q       <= id_d;
      tone_q     <= tone_d;
      active_q   <= active_d;
      done_q     <= done_d;
`ifdef SFX_QUEUE_EN
      pend_vld_q <= pend_vld_d;
      pend_id_q  <= pend_id_d;
`endif
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    idx_d      = idx_q;
    id_d       = id_q;
    done_d     = 1'b0;
    start_c    = 1'b0;
    start_id_c = req_id_c;
    complete_c = 1'b0;
`ifdef SFX_QUEUE_EN
    pend_vld_d = pend_vld_q;
    pend_id_d  = pend_id_q;
`endif

    if (!bus.enable) begin
      state_d = IDLE;
      tick_d  = '0;
      idx_d   = '0;
`ifdef SFX_QUEUE_EN
      pend_vld_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_vld_c) start_c = 1'b1;
        end
        PLAY: begin
          if (req_vld_c && (req_id_c >= id_q)) begin
            // Pre-emption wins even over the last-note terminal count.
            start_c = 1'b1;
`ifdef SFX_QUEUE_EN
            pend_vld_d = 1'b0;
`endif
          end else begin
`ifdef SFX_QUEUE_EN
            if (req_vld_c && (!pend_vld_q || (req_id_c > pend_id_q))) begin
              pend_vld_d = 1'b1;
              pend_id_d  = req_id_c;
            end
`endif
            if (tick_q == NOTE_LAST) begin
              tick_d = '0;
              if (idx_q == last_idx(id_q)) begin
                done_d = 1'b1;
                idx_d  = '0;
                if (GAP_TICKS == 0) complete_c = 1'b1;
                else                state_d    = GAP;
              end else begin
                idx_d = idx_q + 2'd1;
              end
            end else begin
              tick_d = tick_q + CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (req_vld_c) begin
            start_c = 1'b1;
`ifdef SFX_QUEUE_EN
            pend_vld_d = 1'b0;
`endif
          end else if (tick_q == GAP_LAST) begin
            tick_d     = '0;
            complete_c = 1'b1;
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Effect finished: start the pending request if any, else go back to music.
    if (complete_c) begin
      state_d = IDLE;
`ifdef SFX_QUEUE_EN
      if (pend_vld_d) begin
        start_c    = 1'b1;
        start_id_c = pend_id_d;
        pend_vld_d = 1'b0;
      end
`endif
    end

    if (start_c) begin
      state_d = PLAY;
      id_d    = start_id_c;
      idx_d   = '0;
      tick_d  = '0;
    end

    // Tone register follows the state being entered.
    case (state_d)
      PLAY:    tone_d = note_freq(id_d, idx_d);
      GAP:     tone_d = 32'd0;
      default: tone_d = bus.enable ? bus.music_freq : 32'd0;
    endcase
    active_d = (state_d == PLAY);
  end

  assign bus.tone_freq  = tone_q;
  assign bus.sfx_active = active_q;
  assign bus.sfx_id     = id_q;
  assign bus.sfx_done   = done_q;

endmodule

// File: tb/tb_sfx_tone_arbiter.sv
// Directed bench for sfx_tone_arbiter with TICKS_PER_NOTE=4, GAP_TICKS=2, music 440 Hz.
module tb_sfx_tone_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   base;

  sfx_tone_arbiter_if bus ();

  sfx_tone_arbiter #(
    .TICKS_PER_NOTE(4),
    .GAP_TICKS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.sfx_done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected simulation end");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_note(input int id, input int idx);
    logic [31:0] n2 [4];
    logic [31:0] n3 [4];
    n2 = '{32'd523, 32'd659, 32'd784, 32'd1047};
    n3 = '{32'd392, 32'd330, 32'd262, 32'd131};
    if (id == 3) return n3[idx];
    if (id == 2) return n2[idx];
    if (id == 1) return (idx == 0) ? 32'd523 : 32'd262;
    return 32'd988;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // From effect cycle j0 to completion: notes, done pulse, then the two gap cycles.
  task automatic run_rest(input int id, input int j0);
    for (int j = j0; j < 16; j++) begin
      step();
      chk("note_tone", bus.tone_freq, exp_note(id, j / 4));
      chk("note_active", 32'(bus.sfx_active), 32'd1);
      chk("note_done", 32'(bus.sfx_done), 32'd0);
    end
    step();
    chk("done_pulse", 32'(bus.sfx_done), 32'd1);
    chk("gap0_tone", bus.tone_freq, 32'd0);
    chk("gap0_active", 32'(bus.sfx_active), 32'd0);
    step();
    chk("gap1_tone", bus.tone_freq, 32'd0);
    chk("gap1_done", 32'(bus.sfx_done), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.sfx_req = 4'b0000;
    bus.music_freq = 32'd440;
    repeat (3) step();
    chk("rst_tone", bus.tone_freq, 32'd0);
    chk("rst_active", 32'(bus.sfx_active), 32'd0);
    chk("rst_id", 32'(bus.sfx_id), 32'd0);
    chk("rst_done", 32'(bus.sfx_done), 32'd0);

    // 1. idle pass-through
    reset = 1'b0;
    #1;
    chk("release_tone", bus.tone_freq, 32'd0);
    step();
    chk("idle_tone", bus.tone_freq, 32'd440);
    chk("idle_active", 32'(bus.sfx_active), 32'd0);

    // 2. line clear
    bus.sfx_req = 4'b0100;
    step();
    bus.sfx_req = 4'b0000;
    chk("lc_active", 32'(bus.sfx_active), 32'd1);
    chk("lc_id", 32'(bus.sfx_id), 32'd2);
    chk("lc_tone0", bus.tone_freq, 32'd523);
    run_rest(2, 1);
    step();
    chk("lc_music", bus.tone_freq, 32'd440);
    chk("lc_done_cnt", 32'(done_cnt), 32'd1);

    // 3. pre-emption of drop by game over
    bus.sfx_req = 4'b0010;
    step();
    bus.sfx_req = 4'b0000;
    chk("drop_id", 32'(bus.sfx_id), 32'd1);
    chk("drop_tone", bus.tone_freq, 32'd523);
    step();
    chk("drop_tone1", bus.tone_freq, 32'd523);
    bus.sfx_req = 4'b1000;
    step();
    bus.sfx_req = 4'b0000;
    chk("pre_id", 32'(bus.sfx_id), 32'd3);
    chk("pre_tone", bus.tone_freq, 32'd392);
    chk("pre_done", 32'(bus.sfx_done), 32'd0);
    run_rest(3, 1);
    step();
    chk("pre_music", bus.tone_freq, 32'd440);
    chk("pre_done_cnt", 32'(done_cnt), 32'd2);

    // 4. rejection / queue of rotate during line clear
    bus.sfx_req = 4'b0100;
    step();
    bus.sfx_req = 4'b0000;
    step();
    bus.sfx_req = 4'b0001;
    step();
    bus.sfx_req = 4'b0000;
    chk("rej_id", 32'(bus.sfx_id), 32'd2);
    chk("rej_tone", bus.tone_freq, 32'd523);
    run_rest(2, 3);
    step();
`ifdef SFX_QUEUE_EN
    chk("q_tone", bus.tone_freq, 32'd988);
    chk("q_id", 32'(bus.sfx_id), 32'd0);
    chk("q_active", 32'(bus.sfx_active), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("q_hold", bus.tone_freq, 32'd988);
    end
    step();
    chk("q_done", 32'(bus.sfx_done), 32'd1);
    chk("q_gap0", bus.tone_freq, 32'd0);
    step();
    chk("q_gap1", bus.tone_freq, 32'd0);
    step();
    chk("q_music", bus.tone_freq, 32'd440);
    chk("q_done_cnt", 32'(done_cnt), 32'd4);
`else
    chk("rej_music", bus.tone_freq, 32'd440);
    chk("rej_active", 32'(bus.sfx_active), 32'd0);
    chk("rej_done_cnt", 32'(done_cnt), 32'd3);
`endif

    // 5. simultaneous requests
    base = done_cnt;
    bus.sfx_req = 4'b1011;
    step();
    bus.sfx_req = 4'b0000;
    chk("sim_id", 32'(bus.sfx_id), 32'd3);
    chk("sim_tone", bus.tone_freq, 32'd392);
    run_rest(3, 1);
    step();
    chk("sim_music", bus.tone_freq, 32'd440);
    repeat (3) step();
    chk("sim_idle_active", 32'(bus.sfx_active), 32'd0);
    chk("sim_one_done", 32'(done_cnt - base), 32'd1);

    // 6. abort by enable low, then reset mid-effect
    base = done_cnt;
    bus.sfx_req = 4'b0100;
    step();
    bus.sfx_req = 4'b0000;
    repeat (4) step();
    chk("ab_tone", bus.tone_freq, 32'd659);
    bus.enable = 1'b0;
    step();
    chk("ab_off_tone", bus.tone_freq, 32'd0);
    chk("ab_off_active", 32'(bus.sfx_active), 32'd0);
    chk("ab_off_done", 32'(bus.sfx_done), 32'd0);
    bus.sfx_req = 4'b0100;
    step();
    bus.sfx_req = 4'b0000;
    chk("ab_ign_active", 32'(bus.sfx_active), 32'd0);
    chk("ab_ign_tone", bus.tone_freq, 32'd0);
    bus.enable = 1'b1;
    step();
    chk("ab_music", bus.tone_freq, 32'd440);
    chk("ab_done_cnt", 32'(done_cnt - base), 32'd0);

    bus.sfx_req = 4'b0100;
    step();
    bus.sfx_req = 4'b0000;
    repeat (2) step();
    chk("mr_active", 32'(bus.sfx_active), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_tone", bus.tone_freq, 32'd0);
    chk("mr_active0", 32'(bus.sfx_active), 32'd0);
    chk("mr_id", 32'(bus.sfx_id), 32'd0);
    chk("mr_done", 32'(bus.sfx_done), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("mr_music", bus.tone_freq, 32'd440);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
